tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Demultiplexer side of the team's select-based mux datapath: receives a time-division stream of
//  WIDTH-bit samples and distributes slot k to output channel k.
//  A frame-sync strobe aligns slot 0.
//  A complete frame is presented atomically on dout with a one-cycle dout_valid pulse.
//  Sits after the serial mux/link as its receiving end.
// PARAMETERS
//  WIDTH     1  bits per sample/channel
//  CHANNELS  4  slots per frame (>=2); channel counter width CW = $clog2(CHANNELS+1)
// PORTS
//  clk          in   1               single clock, rising edge
//  rst_n        in   1               asynchronous, active-low reset
//  din          in   WIDTH           serial sample
//  din_valid    in   1               din carries a sample this cycle
//  frame_start  in   1               current cycle is slot 0 of a new frame
//  dout         out  CHANNELS*WIDTH  last complete frame; slot k at dout[k*WIDTH +: WIDTH]
//  dout_valid   out  1               one-cycle pulse: dout just updated
//  chan         out  CW              index of next slot expected (0 in IDLE)
//  frame_err    out  1               one-cycle pulse: frame aborted
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; dout=0; dout_valid=0; chan=0; frame_err=0; shadow=0.
//  States:
//   IDLE - din_valid without frame_start ignored.
//          frame_start&din_valid: capture slot 0 into shadow, chan=1, ->RECV.
//          frame_start without din_valid: chan=0, ->RECV.
//   RECV - each din_valid: shadow[chan]<=din, chan<=chan+1.
//          Cycles without din_valid hold all state; no timeout.
//          Slot CHANNELS-1 accepted: dout<={din,shadow[CHANNELS-2:0]} and dout_valid=1 on that
//          same edge (visible next cycle); chan<=0; ->IDLE (PARITY_EN: ->PAR instead).
//  Latency: dout/dout_valid valid 1 clk after last slot sampled; dout_valid never >1 cycle.
//  dout holds its value between frames; partial frames never reach dout.
//  frame_start while in RECV with chan!=0 (short frame):
//   - frame_err=1 for one cycle; shadow discarded; restart as from IDLE in the same cycle.
//   - the din_valid sample in that cycle becomes slot 0.
//  frame_start in the same cycle as the last slot: that sample is slot 0 of the new frame;
//  the old frame is short -> frame_err, no dout_valid.
//  rst_n low mid-frame: everything returns to reset values immediately; no pulses are emitted.
//  Width rules: chan wraps only via explicit reset to 0, never by overflow.
// CONFIGURATION
//  TDM_DEMUX_PARITY_EN defined:
//   - extra state PAR after slot CHANNELS-1: next din_valid carries even parity (XOR) of all
//     CHANNELS*WIDTH data bits in din[0].
//   - match: dout<=shadow, dout_valid=1.
//   - mismatch: dout unchanged, frame_err=1.
//   - either way ->IDLE; latency becomes 1 clk after the parity slot.
//   - frame_start while in PAR is treated as a short frame.
//  Undefined: no PAR state; frame delivered on last data slot; frame_err only on short frame.
// TESTING (WIDTH=1, CHANNELS=4, macro undefined unless noted)
//  1 reset: rst_n=0 -> dout=0, dout_valid=0, chan=0, frame_err=0.
//  2 frame_start with din=1,0,1,1 on 4 consecutive valid cycles -> dout=4'b1101, one dout_valid pulse.
//  3 same frame with din_valid low 3 cycles between slots 1 and 2 -> dout=4'b1101, no early pulse.
//  4 frame_start again after 2 slots -> frame_err pulse; dout keeps 4'b1101; new frame 0,1,1,0 -> dout=4'b0110.
//  5 rst_n=0 after slot 2, then full frame 1,1,1,1 -> dout=4'b1111, no frame_err.
//  6 PARITY_EN: data 1,0,1,1 with parity 1 -> dout=4'b1101, dout_valid pulse;
//    parity 0 -> frame_err pulse, dout unchanged.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: receiving end of the TDM link. Collects CHANNELS serial slots into a
// shadow register and publishes the whole frame on dout with a one-cycle dout_valid
// pulse. A frame_start arriving before the frame completes aborts it with frame_err.
// Optional build macro: TDM_DEMUX_PARITY_EN adds a trailing even-parity slot that
// must match before the frame is published.
module tdm_demux #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned CW      = $clog2(CHANNELS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_start,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic [CW-1:0]             chan,
    output logic                      frame_err
);

    localparam logic [CW-1:0] LastChan = CW'(CHANNELS - 1);

`ifdef TDM_DEMUX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StRecv, StPar} state_t;
`else
    typedef enum logic [1:0] {StIdle, StRecv} state_t;
`endif

    state_t                    state_q, state_d;
    logic [CW-1:0]             chan_q, chan_d;
    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
    logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
    logic                      dout_valid_q, dout_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      restart;

    // State and datapath registers; reset clears everything, including pending pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            chan_q       <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state logic: slot capture, frame completion and short-frame restart.
    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        restart      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    restart = 1'b1;
                end
            end
            StRecv: begin
                if (frame_start) begin
                    // A frame that already holds samples is short; chan==0 is just a re-sync.
                    restart     = 1'b1;
                    frame_err_d = (chan_q != '0);
                end else if (din_valid) begin
                    shadow_d[chan_q*WIDTH +: WIDTH] = din;
                    if (chan_q == LastChan) begin
                        chan_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        state_d = StPar;
`else
                        dout_d       = {din, shadow_q[(CHANNELS-1)*WIDTH-1:0]};
                        dout_valid_d = 1'b1;
                        state_d      = StIdle;
`endif
                    end else begin
                        chan_d = chan_q + 1'b1;
                    end
                end
            end
`ifdef TDM_DEMUX_PARITY_EN
            StPar: begin
                if (frame_start) begin
                    restart     = 1'b1;
                    frame_err_d = 1'b1;
                end else if (din_valid) begin
                    if (din[0] == ^shadow_q) begin
                        dout_d       = shadow_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // Start a new frame this cycle; a valid sample here is slot 0.
        if (restart) begin
            state_d  = StRecv;
            shadow_d = '0;
            if (din_valid) begin
                shadow_d[WIDTH-1:0] = din;
                chan_d              = CW'(1);
            end else begin
                chan_d = '0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign chan       = chan_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux (WIDTH=1, CHANNELS=4): directed vector table, an async
// reset sequence, then randomized traffic against a frame-level reference model.
module tb_tdm_demux;

    localparam int WIDTH    = 1;
    localparam int CHANNELS = 4;
    localparam int CW       = $clog2(CHANNELS + 1);

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [WIDTH-1:0]          din = '0;
    logic                      din_valid = 1'b0;
    logic                      frame_start = 1'b0;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      dout_valid;
    logic [CW-1:0]             chan;
    logic                      frame_err;

    int total = 0;
    int bad   = 0;

    tdm_demux #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_start(frame_start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .chan       (chan),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fs;
        logic       dv;
        logic       d;
        logic [3:0] e_dout;
        logic       e_dv;
        logic [2:0] e_chan;
        logic       e_fe;
    } vec_t;

    vec_t tbl[$];

    // Reference model: frame-level view of the stream.
    bit         m_in_frame;
    bit         m_await_par;
    bit         m_slots[$];
    logic [3:0] m_frame;
    logic [3:0] m_dout;
    logic       m_dv;
    logic       m_fe;

    function automatic void add(logic r, logic fs, logic dv, logic d,
                                logic [3:0] e_dout, logic e_dv, logic [2:0] e_chan, logic e_fe);
        vec_t v;
        v.rst = r; v.fs = fs; v.dv = dv; v.d = d;
        v.e_dout = e_dout; v.e_dv = e_dv; v.e_chan = e_chan; v.e_fe = e_fe;
        tbl.push_back(v);
    endfunction

    function automatic void model_reset();
        m_in_frame  = 1'b0;
        m_await_par = 1'b0;
        m_slots.delete();
        m_frame = '0;
        m_dout  = '0;
        m_dv    = 1'b0;
        m_fe    = 1'b0;
    endfunction

    function automatic void model_step(bit fs, bit dv, bit d);
        m_dv = 1'b0;
        m_fe = 1'b0;
        if (fs) begin
            if (m_await_par || (m_in_frame && m_slots.size() != 0)) m_fe = 1'b1;
            m_await_par = 1'b0;
            m_in_frame  = 1'b1;
            m_slots.delete();
            if (dv) m_slots.push_back(d);
        end else if (m_await_par) begin
            if (dv) begin
                if (d == ^m_frame) begin
                    m_dout = m_frame;
                    m_dv   = 1'b1;
                end else begin
                    m_fe = 1'b1;
                end
                m_await_par = 1'b0;
            end
        end else if (m_in_frame && dv) begin
            m_slots.push_back(d);
            if (m_slots.size() == CHANNELS) begin
                for (int k = 0; k < CHANNELS; k++) m_frame[k] = m_slots[k];
                m_slots.delete();
                m_in_frame = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
                m_await_par = 1'b1;
`else
                m_dout = m_frame;
                m_dv   = 1'b1;
`endif
            end
        end
    endfunction

    function automatic logic [2:0] model_chan();
        return m_in_frame ? 3'(m_slots.size()) : 3'd0;
    endfunction

    task automatic check(string name, int idx, logic [8:0] got, logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got {dout,dv,chan,fe}=%b_%b_%b_%b required %b_%b_%b_%b",
                     name, idx, got[8:5], got[4], got[3:1], got[0],
                     want[8:5], want[4], want[3:1], want[0]);
        end
    endtask

    task automatic step(logic r, logic fs, logic dv, logic d);
        rst_n       = r;
        frame_start = fs;
        din_valid   = dv;
        din         = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] got;
        bit         r_fs, r_dv, r_d, r_rst;

        // Directed table: {rst_n, frame_start, din_valid, din} -> {dout, dv, chan, fe}
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 1, 1, 1, 4'b0000, 0, 0, 0);
`ifndef TDM_DEMUX_PARITY_EN
        // Full frame 1,0,1,1
        add(1, 1, 1, 1, 4'b0000, 0, 1, 0);
        add(1, 0, 1, 0, 4'b0000, 0, 2, 0);
        add(1, 0, 1, 1, 4'b0000, 0, 3, 0);
        add(1, 0, 1, 1, 4'b1101, 1, 0, 0);
        add(1, 0, 0, 0, 4'b1101, 0, 0, 0);
        add(1, 0, 1, 0, 4'b1101, 0, 0, 0);   // valid in IDLE ignored
        // Gapped frame
        add(1, 1, 1, 1, 4'b1101, 0, 1, 0);
        add(1, 0, 1, 0, 4'b1101, 0, 2, 0);
        add(1, 0, 0, 0, 4'b1101, 0, 2, 0);
        add(1, 0, 0, 1, 4'b1101, 0, 2, 0);
        add(1, 0, 0, 0, 4'b1101, 0, 2, 0);
        add(1, 0, 1, 1, 4'b1101, 0, 3, 0);
        add(1, 0, 1, 1, 4'b1101, 1, 0, 0);
        // Short frame, then 0,1,1,0
        add(1, 1, 1, 1, 4'b1101, 0, 1, 0);
        add(1, 0, 1, 1, 4'b1101, 0, 2, 0);
        add(1, 1, 1, 0, 4'b1101, 0, 1, 1);
        add(1, 0, 1, 1, 4'b1101, 0, 2, 0);
        add(1, 0, 1, 1, 4'b1101, 0, 3, 0);
        add(1, 0, 1, 0, 4'b0110, 1, 0, 0);
        // Reset mid-frame, then 1,1,1,1 via frame_start without valid
        add(1, 1, 1, 1, 4'b0110, 0, 1, 0);
        add(1, 0, 1, 1, 4'b0110, 0, 2, 0);
        add(0, 0, 0, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 0);   // re-sync with chan==0: no error
        add(1, 0, 1, 1, 4'b0000, 0, 1, 0);
        add(1, 0, 1, 1, 4'b0000, 0, 2, 0);
        add(1, 0, 1, 1, 4'b0000, 0, 3, 0);
        add(1, 0, 1, 1, 4'b1111, 1, 0, 0);
        // frame_start on the last slot: short frame, sample becomes slot 0
        add(1, 1, 1, 0, 4'b1111, 0, 1, 0);
        add(1, 0, 1, 0, 4'b1111, 0, 2, 0);
        add(1, 0, 1, 0, 4'b1111, 0, 3, 0);
        add(1, 1, 1, 1, 4'b1111, 0, 1, 1);
        add(1, 0, 1, 0, 4'b1111, 0, 2, 0);
        add(1, 0, 1, 0, 4'b1111, 0, 3, 0);
        add(1, 0, 1, 0, 4'b0001, 1, 0, 0);
`else
        // Frame 1,0,1,1 with good parity 1
        add(1, 1, 1, 1, 4'b0000, 0, 1, 0);
        add(1, 0, 1, 0, 4'b0000, 0, 2, 0);
        add(1, 0, 1, 1, 4'b0000, 0, 3, 0);
        add(1, 0, 1, 1, 4'b0000, 0, 0, 0);
        add(1, 0, 1, 1, 4'b1101, 1, 0, 0);
        // Frame 0,1,1,0 with bad parity 1
        add(1, 1, 1, 0, 4'b1101, 0, 1, 0);
        add(1, 0, 1, 1, 4'b1101, 0, 2, 0);
        add(1, 0, 1, 1, 4'b1101, 0, 3, 0);
        add(1, 0, 1, 0, 4'b1101, 0, 0, 0);
        add(1, 0, 1, 1, 4'b1101, 0, 0, 1);
`endif

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].fs, tbl[i].dv, tbl[i].d);
            got = {dout, dout_valid, chan, frame_err};
            check("vec", i, got, {tbl[i].e_dout, tbl[i].e_dv, tbl[i].e_chan, tbl[i].e_fe});
        end

        // Async reset asserted between edges clears outputs without a clock.
        step(1, 1, 1, 1);
        step(1, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        got = {dout, dout_valid, chan, frame_err};
        check("async_rst", 0, got, 9'b0);
        @(posedge clk);
        #1;
        got = {dout, dout_valid, chan, frame_err};
        check("async_rst", 1, got, 9'b0);

        // Randomized traffic against the model.
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_fs  = ($urandom_range(0, 9) == 0);
            r_dv  = ($urandom_range(0, 3) != 0);
            r_d   = 1'($urandom);
            step(!r_rst, r_fs, r_dv, r_d);
            if (r_rst) model_reset();
            else model_step(r_fs, r_dv, r_d);
            got = {dout, dout_valid, chan, frame_err};
            check("rand", i, got, {m_dout, m_dv, model_chan(), m_fe});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
